// File: rtl/mmc3_scanline_irq_if.sv
// mmc3_scanline_irq_if: mapper register write bus from the upstream address decode
interface mmc3_scanline_irq_if;
    logic       reg_write;
    logic [1:0] reg_sel;
    logic       reg_a0;
    logic [7:0] reg_data;
    modport master (output reg_write, reg_sel, reg_a0, reg_data);
    modport slave  (input  reg_write, reg_sel, reg_a0, reg_data);
endinterface

// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3-style scanline counter clocked by filtered PPU A12 rises, active-low irq
module mmc3_scanline_irq #(
    parameter int unsigned FILTER_CYCLES = 3,
    parameter bit          ALT_IRQ       = 1'b0
) (
    input  logic                m2,
    input  logic                rst_n,
    mmc3_scanline_irq_if.slave  bus,
    input  logic                ppu_a12,
    output logic                irq,
    output logic [7:0]          counter_dbg
);
    localparam logic [3:0] FILT = FILTER_CYCLES[3:0];

    logic [1:0] sync;
    logic       a12_prev;
    logic [3:0] low_cnt;
    logic [7:0] latch;
    logic [7:0] counter;
    logic       reload;
    logic       enable;
    logic       pending;

    logic       a12_s;
    logic       wr_c000;
    logic       wr_c001;
    logic       wr_e000;
    logic       wr_e001;
    logic       valid_edge;
    logic       clk_cnt;
    logic       reload_path;
    logic [7:0] cnt_next;
    logic       irq_cond;
    logic [3:0] low_cnt_next;

    always_comb begin
        a12_s        = sync[1];
        wr_c000      = bus.reg_write && bus.reg_sel == 2'b10 && !bus.reg_a0;
        wr_c001      = bus.reg_write && bus.reg_sel == 2'b10 &&  bus.reg_a0;
        wr_e000      = bus.reg_write && bus.reg_sel == 2'b11 && !bus.reg_a0;
        wr_e001      = bus.reg_write && bus.reg_sel == 2'b11 &&  bus.reg_a0;
        valid_edge   = a12_s && !a12_prev && low_cnt >= FILT;
        // a $C001 write in the same cycle swallows the edge
        clk_cnt      = valid_edge && !wr_c001;
        reload_path  = counter == 8'd0 || reload;
        cnt_next     = reload_path ? latch : counter - 8'd1;
        irq_cond     = enable && cnt_next == 8'd0 &&
                       (!ALT_IRQ || ((counter != 8'd0 || reload) && (!reload_path || latch != 8'd0)));
        low_cnt_next = a12_s ? 4'd0 : (low_cnt == 4'hf ? low_cnt : low_cnt + 4'd1);
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b00;
            a12_prev <= 1'b0;
            low_cnt  <= 4'd0;
            latch    <= 8'd0;
            counter  <= 8'd0;
            reload   <= 1'b0;
            enable   <= 1'b0;
            pending  <= 1'b0;
            irq      <= 1'b1;
        end else begin
            sync     <= {sync[0], ppu_a12};
            a12_prev <= a12_s;
            low_cnt  <= low_cnt_next;
            irq      <= ~pending;
            if (wr_c000)
                latch <= bus.reg_data;
            if (wr_c001) begin
                counter <= 8'd0;
                reload  <= 1'b1;
            end else if (clk_cnt) begin
                counter <= cnt_next;
                reload  <= 1'b0;
            end
            if (wr_e000)
                enable <= 1'b0;
            else if (wr_e001)
                enable <= 1'b1;
            if (wr_e000)
                pending <= 1'b0;
            else if (clk_cnt && irq_cond)
                pending <= 1'b1;
        end
    end

    assign counter_dbg = counter;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: new (ALT_IRQ=0) and old (ALT_IRQ=1) variants share one stimulus stream
module tb_mmc3_scanline_irq;
    logic       m2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ppu_a12 = 1'b1;
    logic       irq_a, irq_b;
    logic [7:0] cnt_a, cnt_b;
    int         n_chk = 0;
    int         n_bad = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       ia;
        logic       ib;
    } exp_t;
    exp_t exp_q[$];

    mmc3_scanline_irq_if bus ();

    mmc3_scanline_irq #(.FILTER_CYCLES(3), .ALT_IRQ(1'b0)) dut_a (
        .m2(m2), .rst_n(rst_n), .bus(bus), .ppu_a12(ppu_a12), .irq(irq_a), .counter_dbg(cnt_a));
    mmc3_scanline_irq #(.FILTER_CYCLES(3), .ALT_IRQ(1'b1)) dut_b (
        .m2(m2), .rst_n(rst_n), .bus(bus), .ppu_a12(ppu_a12), .irq(irq_b), .counter_dbg(cnt_b));

    always #5 m2 = ~m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge m2);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic a0, input logic [7:0] d);
        bus.reg_write = 1'b1;
        bus.reg_sel   = sel;
        bus.reg_a0    = a0;
        bus.reg_data  = d;
        tick(1);
        bus.reg_write = 1'b0;
    endtask

    // A12 low for `low` cycles then high; optional write timed onto the counter-update edge
    task automatic pulse(input string tag, input int low, input logic [7:0] ec, input logic ea,
                         input logic eb, input bit at_edge, input logic [1:0] sel, input logic a0,
                         input logic [7:0] d, input bit lat);
        exp_t e;
        int k;
        logic [7:0] c0;
        exp_q.push_back(exp_t'{ec, ea, eb});
        c0 = cnt_a;
        k = 0;
        ppu_a12 = 1'b0;
        tick(low);
        ppu_a12 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (at_edge && i == 3) begin
                bus.reg_write = 1'b1;
                bus.reg_sel   = sel;
                bus.reg_a0    = a0;
                bus.reg_data  = d;
            end
            tick(1);
            if (at_edge && i == 3)
                bus.reg_write = 1'b0;
            if (k == 0 && cnt_a !== c0) begin
                k = i;
                if (lat) chk({tag, "_irq_with_cnt"}, irq_a, 1);
            end else if (lat && k != 0 && i == k + 1) begin
                chk({tag, "_irq_next_edge"}, irq_a, 0);
            end
        end
        if (lat) chk({tag, "_latency"}, k >= 2 && k <= 3, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_cnt_a"}, cnt_a, e.cnt);
            chk({tag, "_cnt_b"}, cnt_b, e.cnt);
            chk({tag, "_irq_a"}, irq_a, e.ia);
            chk({tag, "_irq_b"}, irq_b, e.ib);
        end
    endtask

    initial begin
        bus.reg_write = 1'b0;
        bus.reg_sel   = 2'b00;
        bus.reg_a0    = 1'b0;
        bus.reg_data  = 8'd0;
        tick(3);
        chk("rst_irq_a", irq_a, 1);
        chk("rst_irq_b", irq_b, 1);
        chk("rst_cnt_a", cnt_a, 0);
        rst_n = 1'b1;
        tick(4);
        for (int i = 0; i < 10; i++) pulse("idle", 8, 8'd0, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b10, 0, 8'd3);
        wr(2'b10, 1, 8'd0);
        wr(2'b11, 1, 8'd0);
        pulse("dn3", 8, 8'd3, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("dn2", 8, 8'd2, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("dn1", 8, 8'd1, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("dn0", 8, 8'd0, 0, 0, 0, 2'b00, 0, 8'd0, 1);
        wr(2'b11, 0, 8'd0);
        chk("ack_hold_a", irq_a, 0);
        tick(1);
        chk("ack_a", irq_a, 1);
        chk("ack_b", irq_b, 1);
        wr(2'b11, 1, 8'd0);
        tick(3);
        chk("reen_a", irq_a, 1);
        chk("reen_b", irq_b, 1);
        pulse("rl3", 8, 8'd3, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("rl2", 8, 8'd2, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("rl1", 8, 8'd1, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("rl0", 8, 8'd0, 0, 0, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b11, 0, 8'd0);
        wr(2'b11, 1, 8'd0);
        pulse("flt2", 2, 8'd0, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("flt3", 3, 8'd3, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("flt3b", 3, 8'd2, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("flt2b", 2, 8'd2, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b10, 0, 8'd0);
        wr(2'b10, 1, 8'd0);
        for (int i = 0; i < 5; i++) pulse("latch0", 8, 8'd0, 0, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b11, 0, 8'd0);
        wr(2'b10, 0, 8'd5);
        wr(2'b11, 1, 8'd0);
        pulse("s_load", 8, 8'd5, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("s_dec", 8, 8'd4, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        pulse("s_c001", 8, 8'd0, 1, 1, 1, 2'b10, 1, 8'd0, 0);
        pulse("s_c000", 8, 8'd5, 1, 1, 1, 2'b10, 0, 8'd7, 0);
        pulse("s_dec2", 8, 8'd4, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b10, 1, 8'd0);
        pulse("s_new", 8, 8'd7, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b10, 0, 8'd0);
        wr(2'b10, 1, 8'd0);
        pulse("r_irq", 8, 8'd0, 0, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b10, 0, 8'd9);
        pulse("r_cnt", 8, 8'd9, 0, 1, 0, 2'b00, 0, 8'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_irq_a", irq_a, 1);
        chk("rst_mid_cnt_a", cnt_a, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        pulse("r_en_off", 8, 8'd0, 1, 1, 0, 2'b00, 0, 8'd0, 0);
        wr(2'b11, 1, 8'd0);
        pulse("r_latch", 8, 8'd0, 0, 1, 0, 2'b00, 0, 8'd0, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
